// File: rtl/montgomery_exp_param.sv
// rtl/montgomery_exp_param.sv - x^e mod m controller driving an external Montgomery multiplier
// Supports left-to-right square-and-multiply and a constant-time Montgomery ladder.
module montgomery_exp_param #(
  parameter int WIDTH = 512,
  parameter int EBW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] e,
  input  logic [EBW-1:0]   ebits,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] r_modm,
  input  logic [WIDTH-1:0] r2_modm,
  output logic             mult_start,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic [WIDTH-1:0] mult_m,
  input  logic [WIDTH-1:0] mult_res,
  input  logic             mult_done,
  output logic             busy,
  output logic [WIDTH-1:0] res,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_XT_REQ    = 4'd1;
  localparam logic [3:0] S_XT_WAIT   = 4'd2;
  localparam logic [3:0] S_BIT_CHECK = 4'd3;
  localparam logic [3:0] S_OP1_REQ   = 4'd4;
  localparam logic [3:0] S_OP1_WAIT  = 4'd5;
  localparam logic [3:0] S_OP2_REQ   = 4'd6;
  localparam logic [3:0] S_OP2_WAIT  = 4'd7;
  localparam logic [3:0] S_FIN_REQ   = 4'd8;
  localparam logic [3:0] S_FIN_WAIT  = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]       state;
  logic             mode_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] rmod_q;
  logic [WIDTH-1:0] r2_q;
  logic [WIDTH-1:0] xt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] r0_q;
  logic [WIDTH-1:0] r1_q;
  logic [EBW-1:0]   eb_q;
  logic [EBW-1:0]   cnt_q;
  logic [IW-1:0]    idx_q;
  logic [EBW-1:0]   eb_clamped;
  logic             cur_bit;

  assign eb_clamped = (ebits > EBW'(WIDTH)) ? EBW'(WIDTH) : ebits;
  assign cur_bit    = e_q[idx_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      x_q        <= '0;
      e_q        <= '0;
      rmod_q     <= '0;
      r2_q       <= '0;
      xt_q       <= '0;
      a_q        <= '0;
      r0_q       <= '0;
      r1_q       <= '0;
      eb_q       <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      mult_start <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      mult_m     <= '0;
      busy       <= 1'b0;
      res        <= '0;
      done       <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q    <= x;
            e_q    <= e;
            eb_q   <= eb_clamped;
            mult_m <= m;
            mode_q <= mode;
            rmod_q <= r_modm;
            r2_q   <= r2_modm;
            busy   <= 1'b1;
            state  <= S_XT_REQ;
          end
        end

        // Bring x into the Montgomery domain: x*R^2*R^-1 = x*R mod m.
        S_XT_REQ: begin
          mult_start <= 1'b1;
          mult_a     <= x_q;
          mult_b     <= r2_q;
          state      <= S_XT_WAIT;
        end

        S_XT_WAIT: begin
          if (mult_done) begin
            xt_q  <= mult_res;
            r1_q  <= mult_res;
            a_q   <= rmod_q;
            r0_q  <= rmod_q;
            idx_q <= IW'(eb_q - 1'b1);
            cnt_q <= eb_q;
            state <= S_BIT_CHECK;
          end
        end

        // The counter, not the index, terminates the loop so ebits = WIDTH works.
        S_BIT_CHECK: begin
          state <= (cnt_q == '0) ? S_FIN_REQ : S_OP1_REQ;
        end

        S_OP1_REQ: begin
          mult_start <= 1'b1;
          if (mode_q) begin
            mult_a <= r0_q;
            mult_b <= r1_q;
          end else begin
            mult_a <= a_q;
            mult_b <= a_q;
          end
          state <= S_OP1_WAIT;
        end

        S_OP1_WAIT: begin
          if (mult_done) begin
            if (mode_q) begin
              if (cur_bit) r0_q <= mult_res;
              else         r1_q <= mult_res;
              state <= S_OP2_REQ;
            end else begin
              a_q <= mult_res;
              if (cur_bit) begin
                state <= S_OP2_REQ;
              end else begin
                idx_q <= idx_q - 1'b1;
                cnt_q <= cnt_q - 1'b1;
                state <= S_BIT_CHECK;
              end
            end
          end
        end

        // Ladder squares whichever register OP1 left untouched.
        S_OP2_REQ: begin
          mult_start <= 1'b1;
          if (mode_q) begin
            mult_a <= cur_bit ? r1_q : r0_q;
            mult_b <= cur_bit ? r1_q : r0_q;
          end else begin
            mult_a <= a_q;
            mult_b <= xt_q;
          end
          state <= S_OP2_WAIT;
        end

        S_OP2_WAIT: begin
          if (mult_done) begin
            if (mode_q) begin
              if (cur_bit) r1_q <= mult_res;
              else         r0_q <= mult_res;
            end else begin
              a_q <= mult_res;
            end
            idx_q <= idx_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
            state <= S_BIT_CHECK;
          end
        end

        // Multiplying by plain 1 strips the R factor and leaves the ordinary residue.
        S_FIN_REQ: begin
          mult_start <= 1'b1;
          mult_a     <= mode_q ? r0_q : a_q;
          mult_b     <= ONE;
          state      <= S_FIN_WAIT;
        end

        S_FIN_WAIT: begin
          if (mult_done) begin
            res   <= mult_res;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_exp_param.sv
// tb/tb_montgomery_exp_param.sv - self-checking bench for montgomery_exp_param
`timescale 1ns/1ps
module tb_montgomery_exp_param;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        s_start, s_mode;
  logic [15:0] s_x, s_e, s_m, s_r, s_r2;
  logic [4:0]  s_eb;
  logic        s_ms, s_mdone, s_busy, s_done;
  logic [15:0] s_ma, s_mb, s_mm, s_mres, s_res;

  logic         b_start, b_mode;
  logic [511:0] b_x, b_e, b_m, b_r, b_r2;
  logic [9:0]   b_eb;
  logic         b_ms, b_mdone, b_busy, b_done;
  logic [511:0] b_ma, b_mb, b_mm, b_mres, b_res;

  int checks = 0;
  int errors = 0;
  int lat16  = -1;
  int s_mcnt = 0, s_dcnt = 0, s_stab = 0, s_ovl = 0;
  int b_mcnt = 0, b_dcnt = 0;

  montgomery_exp_param #(.WIDTH(16)) dut16 (
    .clk(clk), .resetn(resetn), .start(s_start), .mode(s_mode),
    .x(s_x), .e(s_e), .ebits(s_eb), .m(s_m), .r_modm(s_r), .r2_modm(s_r2),
    .mult_start(s_ms), .mult_a(s_ma), .mult_b(s_mb), .mult_m(s_mm),
    .mult_res(s_mres), .mult_done(s_mdone),
    .busy(s_busy), .res(s_res), .done(s_done)
  );

  montgomery_exp_param #(.WIDTH(512)) dut512 (
    .clk(clk), .resetn(resetn), .start(b_start), .mode(b_mode),
    .x(b_x), .e(b_e), .ebits(b_eb), .m(b_m), .r_modm(b_r), .r2_modm(b_r2),
    .mult_start(b_ms), .mult_a(b_ma), .mult_b(b_mb), .mult_m(b_mm),
    .mult_res(b_mres), .mult_done(b_mdone),
    .busy(b_busy), .res(b_res), .done(b_done)
  );

  // Montgomery product a*b*2^-n mod m, computed bit-serially.
  function automatic logic [511:0] montmul(input logic [511:0] a, input logic [511:0] b,
                                           input logic [511:0] m, input int n);
    logic [1025:0] t;
    t = 1026'(a) * 1026'(b);
    for (int i = 0; i < n; i++) begin
      if (t[0]) t = t + 1026'(m);
      t = t >> 1;
    end
    if (t >= 1026'(m)) t = t - 1026'(m);
    return t[511:0];
  endfunction

  function automatic logic [511:0] ref_exp(input logic [511:0] x, input logic [511:0] e,
                                           input logic [511:0] m, input int eb, input int w);
    logic [1023:0] r, xx, mm;
    if (eb > w) eb = w;
    mm = 1024'(m);
    xx = 1024'(x);
    r  = 1024'(1) % mm;
    for (int i = eb - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * xx) % mm;
    end
    return r[511:0];
  endfunction

  function automatic int exp_cnt(input logic [511:0] e, input int eb, input logic md, input int w);
    int n;
    if (eb > w) eb = w;
    n = 2;
    for (int i = 0; i < eb; i++) n += md ? 2 : (1 + int'(e[i]));
    return n;
  endfunction

  function automatic logic [511:0] rmodw(input logic [511:0] m, input int w);
    logic [1024:0] big;
    big = 1025'(1) << w;
    return 512'(big % 1025'(m));
  endfunction

  function automatic logic [511:0] r2mod(input logic [511:0] r, input logic [511:0] m);
    logic [1023:0] t;
    t = (1024'(r) * 1024'(r)) % 1024'(m);
    return t[511:0];
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // External multiplier models: detect a request on the falling edge, answer after a latency.
  initial begin
    logic [511:0] ta, tb_, tm;
    int lat;
    s_mdone = 1'b0;
    s_mres  = '0;
    forever begin
      @(negedge clk);
      if (s_ms && resetn) begin
        ta = 512'(s_ma); tb_ = 512'(s_mb); tm = 512'(s_mm);
        if (lat16 >= 0) lat = lat16;
        else lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
        repeat (lat) @(negedge clk);
        #2;
        s_mres  = 16'(montmul(ta, tb_, tm, 16));
        s_mdone = 1'b1;
        @(negedge clk);
        #2;
        s_mdone = 1'b0;
      end
    end
  end

  initial begin
    logic [511:0] ta, tb_, tm;
    b_mdone = 1'b0;
    b_mres  = '0;
    forever begin
      @(negedge clk);
      if (b_ms && resetn) begin
        ta = b_ma; tb_ = b_mb; tm = b_mm;
        repeat (2) @(negedge clk);
        #2;
        b_mres  = montmul(ta, tb_, tm, 512);
        b_mdone = 1'b1;
        @(negedge clk);
        #2;
        b_mdone = 1'b0;
      end
    end
  end

  // Request counting and operand-hold monitoring.
  initial begin
    bit out16 = 0;
    logic [15:0] ha = '0, hb = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        out16 = 0;
      end else begin
        if (s_ms) begin
          s_mcnt++;
          if (out16) s_ovl++;
          out16 = 1; ha = s_ma; hb = s_mb;
        end else if (out16 && (s_ma !== ha || s_mb !== hb)) begin
          s_stab++;
        end
        if (s_mdone) out16 = 0;
      end
      if (s_done) s_dcnt++;
      if (b_ms && resetn) b_mcnt++;
      if (b_done) b_dcnt++;
    end
  end

  task automatic run(input int sel, input logic [511:0] x, input logic [511:0] e,
                     input logic [511:0] m, input int eb, input logic md, input bit noise,
                     input string tag, output logic [511:0] res, output int nm);
    int w, c0, d0, first_ms;
    bit got;
    logic [511:0] r, r2;
    w  = (sel == 0) ? 16 : 512;
    r  = rmodw(m, w);
    r2 = r2mod(r, m);
    res = '0;
    @(negedge clk);
    if (sel == 0) begin
      s_x = x[15:0]; s_e = e[15:0]; s_m = m[15:0]; s_r = r[15:0]; s_r2 = r2[15:0];
      s_eb = 5'(eb); s_mode = md; s_start = 1'b1;
      c0 = s_mcnt; d0 = s_dcnt;
    end else begin
      b_x = x; b_e = e; b_m = m; b_r = r; b_r2 = r2;
      b_eb = 10'(eb); b_mode = md; b_start = 1'b1;
      c0 = b_mcnt; d0 = b_dcnt;
    end
    first_ms = -1;
    got = 0;
    for (int cyc = 1; cyc <= 4000 && !got; cyc++) begin
      @(negedge clk);
      if (sel == 0) begin
        if (first_ms < 0 && s_ms) first_ms = cyc;
        if (cyc == 1) chk({tag, " busy_rise"}, 512'(s_busy), 512'(1));
        if (s_done) begin
          got = 1;
          s_start = 1'b0;
          chk({tag, " busy_fall"}, 512'(s_busy), 512'(0));
          res = 512'(s_res);
        end else begin
          s_start = noise && s_busy && ($urandom_range(0, 5) == 0);
          if (noise) begin
            s_x = 16'($urandom); s_e = 16'($urandom); s_eb = 5'($urandom);
            s_m = 16'($urandom); s_r = 16'($urandom); s_r2 = 16'($urandom);
            s_mode = 1'($urandom);
          end
        end
      end else begin
        if (first_ms < 0 && b_ms) first_ms = cyc;
        if (cyc == 1) chk({tag, " busy_rise"}, 512'(b_busy), 512'(1));
        b_start = 1'b0;
        if (b_done) begin
          got = 1;
          chk({tag, " busy_fall"}, 512'(b_busy), 512'(0));
          res = b_res;
        end
      end
    end
    chk({tag, " timeout"}, 512'(got), 512'(1));
    @(negedge clk);
    if (sel == 0) begin
      chk({tag, " done_one_cycle"}, 512'(s_done), 512'(0));
      chk({tag, " done_count"}, 512'(s_dcnt - d0), 512'(1));
      nm = s_mcnt - c0;
    end else begin
      chk({tag, " done_count"}, 512'(b_dcnt - d0), 512'(1));
      nm = b_mcnt - c0;
    end
    chk({tag, " first_req_latency"}, 512'(first_ms > 0 && first_ms <= 2), 512'(1));
  endtask

  task automatic dir16(input string tag, input int x, input int e, input int eb,
                       input logic md, input int exp_res, input int exp_n);
    logic [511:0] got_res;
    int nm;
    run(0, 512'(x), 512'(e), 512'(13), eb, md, 1'b0, tag, got_res, nm);
    chk({tag, " res"}, got_res, 512'(exp_res));
    chk({tag, " mults"}, 512'(nm), 512'(exp_n));
  endtask

  initial begin
    logic [511:0] got_res, bm, ref_v;
    int nm, c0, c1, d1, k, mi, xi, ei, eb;
    logic md;
    resetn = 1'b0;
    s_start = 1'b0; s_mode = 1'b0; s_x = '0; s_e = '0; s_m = '0; s_r = '0; s_r2 = '0; s_eb = '0;
    b_start = 1'b0; b_mode = 1'b0; b_x = '0; b_e = '0; b_m = '0; b_r = '0; b_r2 = '0; b_eb = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset busy", 512'(s_busy), 512'(0));
    chk("reset done", 512'(s_done), 512'(0));
    chk("reset mult_start", 512'(s_ms), 512'(0));
    chk("reset res", 512'(s_res), 512'(0));
    chk("reset mult_a", 512'(s_ma), 512'(0));
    chk("reset mult_b", 512'(s_mb), 512'(0));
    chk("reset mult_m", 512'(s_mm), 512'(0));
    chk("reset busy512", 512'(b_busy), 512'(0));
    chk("reset res512", b_res, 512'(0));

    dir16("e3_sqm", 5, 3, 2, 1'b0, 8, 6);
    dir16("e11_sqm", 5, 11, 4, 1'b0, 8, 9);
    dir16("e11_ladder", 5, 11, 4, 1'b1, 8, 10);
    dir16("eb0_sqm", 5, 16'hABCD, 0, 1'b0, 1, 2);
    dir16("eb0_ladder", 5, 16'h1234, 0, 1'b1, 1, 2);
    dir16("eFF_eb2", 5, 8'hFF, 2, 1'b0, 8, 6);
    dir16("x0", 0, 5, 3, 1'b0, 0, 7);
    dir16("x0_ladder", 0, 5, 3, 1'b1, 0, 8);

    ei = int'($urandom_range(0, 65535));
    run(0, 512'(7), 512'(ei), 512'(13), 20, 1'b1, 1'b0, "clamp", got_res, nm);
    chk("clamp res", got_res, ref_exp(512'(7), 512'(ei), 512'(13), 16, 16));
    chk("clamp mults", 512'(nm), 512'(34));

    // Reset while the first squaring is outstanding; its late completion must be ignored.
    lat16 = 10;
    @(negedge clk);
    s_x = 16'd5; s_e = 16'd3; s_eb = 5'd2; s_mode = 1'b0; s_m = 16'd13; s_r = 16'd3; s_r2 = 16'd9;
    s_start = 1'b1;
    c0 = s_mcnt;
    @(negedge clk);
    s_start = 1'b0;
    k = 0;
    while ((s_mcnt - c0) < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rst reached op1", 512'(s_mcnt - c0), 512'(2));
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    c1 = s_mcnt;
    d1 = s_dcnt;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst busy", 512'(s_busy), 512'(0));
    chk("post_rst done_count", 512'(s_dcnt - d1), 512'(0));
    chk("post_rst mult_count", 512'(s_mcnt - c1), 512'(0));
    chk("post_rst res", 512'(s_res), 512'(0));
    chk("post_rst mult_a", 512'(s_ma), 512'(0));
    chk("post_rst mult_b", 512'(s_mb), 512'(0));
    chk("post_rst mult_m", 512'(s_mm), 512'(0));
    lat16 = -1;
    dir16("after_rst", 5, 3, 2, 1'b0, 8, 6);

    for (int v = 0; v < 500; v++) begin
      mi = int'($urandom_range(3, 65535)) | 1;
      xi = int'($urandom_range(0, mi - 1));
      ei = int'($urandom_range(0, 65535));
      eb = ($urandom_range(0, 15) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
      md = 1'($urandom);
      run(0, 512'(xi), 512'(ei), 512'(mi), eb, md, 1'b1, "rnd", got_res, nm);
      chk("rnd res", got_res, ref_exp(512'(xi), 512'(ei), 512'(mi), eb, 16));
      chk("rnd mults", 512'(nm), 512'(exp_cnt(512'(ei), eb, md, 16)));
    end
    chk("operand hold", 512'(s_stab), 512'(0));
    chk("request overlap", 512'(s_ovl), 512'(0));

    for (int i = 0; i < 16; i++) bm[i*32 +: 32] = $urandom;
    bm[511] = 1'b1;
    bm[0]   = 1'b1;
    ref_v = ref_exp(512'(2), 512'(65537), bm, 17, 512);
    run(1, 512'(2), 512'(65537), bm, 17, 1'b0, 1'b0, "w512_sqm", got_res, nm);
    chk("w512_sqm res", got_res, ref_v);
    chk("w512_sqm mults", 512'(nm), 512'(21));
    run(1, 512'(2), 512'(65537), bm, 17, 1'b1, 1'b0, "w512_ladder", got_res, nm);
    chk("w512_ladder res", got_res, ref_v);
    chk("w512_ladder mults", 512'(nm), 512'(36));
    chk("w512 mult_m", b_mm, bm);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, observed still running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/montgomery_exp_param.md
Name: montgomery_exp_param

Overview:
Parametrised successor to the fixed 512-bit Montgomery exponentiation controller. It computes res = x^e mod m using an external Montgomery multiplier, MontMul(a,b) = a*b*R^-1 mod m with R = 2^WIDTH, through a request/acknowledge port. It adds a runtime exponent bit-length and a selectable constant-time Montgomery-ladder mode. It sits between the CPU-facing register interface and the shared montgomery multiplier core.

Parameters:
WIDTH, 512, operand and modulus width in bits; R = 2^WIDTH
EBW, $clog2(WIDTH)+1, width of ebits port

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; sampled only in IDLE
mode  in  1  0 = left-to-right square-and-multiply, 1 = Montgomery ladder
x  in  WIDTH  base, x < m
e  in  WIDTH  exponent
ebits  in  EBW  number of exponent bits processed, e[ebits-1:0]; 0..WIDTH
m  in  WIDTH  odd modulus
r_modm  in  WIDTH  R mod m, precomputed by software
r2_modm  in  WIDTH  R^2 mod m, precomputed by software
mult_start  out  1  one-cycle multiplier request
mult_a  out  WIDTH  multiplier operand a
mult_b  out  WIDTH  multiplier operand b
mult_m  out  WIDTH  latched modulus
mult_res  in  WIDTH  multiplier result; valid when mult_done = 1
mult_done  in  1  one-cycle completion pulse from the multiplier
busy  out  1  high from the cycle after start is accepted until done
res  out  WIDTH  result; held until the next accepted start
done  out  1  one-cycle pulse when res is valid

Behaviour:
- Reset: all state returns to IDLE. busy, done and mult_start are 0. res, mult_a, mult_b, mult_m and the internal A, R0, R1, XT and bit index are all 0. Reset is asynchronous and may occur at any time, including mid-operation. No pending multiplier result is honoured after reset; a mult_done arriving after reset is ignored.
- Start acceptance: start is accepted only when it is sampled in IDLE. On that edge the block latches x, e, ebits, m, mode, r_modm and r2_modm, and busy rises. A start received while busy is ignored. The latched copies remain valid even if the inputs change afterwards.
- Multiplier handshake:
  - Each multiplication drives mult_a and mult_b and pulses mult_start high for exactly one cycle.
  - mult_a and mult_b are held stable until mult_done.
  - The block waits an unbounded number of cycles for mult_done. mult_done is ignored in every state except a WAIT state.
  - The result is captured on the mult_done edge.
  - The next mult_start occurs no earlier than 1 cycle after mult_done.
- States: IDLE, XT_REQ/XT_WAIT, BIT_CHECK, OP1_REQ/OP1_WAIT, OP2_REQ/OP2_WAIT, FIN_REQ/FIN_WAIT, DONE.
- Common prologue: XT = MontMul(x, r2_modm). Then A = R0 = r_modm, R1 = XT, and the bit index is set to ebits-1.
- BIT_CHECK: if the bits-remaining counter is 0, go to FIN; otherwise perform the per-bit operations below.
- Square-and-multiply mode (mode = 0), for each bit:
  - OP1: A = MontMul(A, A).
  - If e[i] = 1: OP2: A = MontMul(A, XT).
  - If e[i] = 0: OP2 is skipped.
- Ladder mode (mode = 1), for each bit:
  - If e[i] = 0: OP1: R1 = MontMul(R0, R1), then OP2: R0 = MontMul(R0, R0).
  - If e[i] = 1: OP1: R0 = MontMul(R0, R1), then OP2: R1 = MontMul(R1, R1).
  - Both operations always run, so the multiplication count is independent of e.
- Bit index decrement: the index decrements after each bit. Termination is driven by the counter, not by index wrap, so ebits = WIDTH is legal.
- FIN: res = MontMul(A or R0, 1), with operand b = 1 (zero-extended to WIDTH). DONE: res is registered, done pulses for 1 cycle, busy falls in the same cycle, and the block returns to IDLE.
- Multiplication count:
  - mode 0: 2 + ebits + popcount(e[ebits-1:0])
  - mode 1: 2 + 2*ebits
- Boundary cases:
  - ebits = 0: res = MontMul(r_modm, 1) = 1 (for m > 1), using 2 multiplications.
  - x = 0 with ebits > 0: res = 0.
  - Bits of e above ebits-1 are ignored.
  - ebits > WIDTH is clamped to WIDTH.
- Overhead latency: excluding multiplier wait time, the block adds at most 3 cycles per multiplication, plus 2 cycles from start to the first mult_start.

Test Plan:
- WIDTH=8, m=13, r_modm=9, r2_modm=3, x=5, e=3, ebits=2, mode=0 -> res=8; exactly 6 mult_start pulses; done pulses once; busy falls with done.
- Same operands with e=11, ebits=4: mode=0 -> res=8 with 9 multiplications; mode=1 -> res=8 with 10 multiplications.
- ebits=0 with any e -> res=1 after 2 multiplications. e=0xFF with ebits=2 behaves identically to e=3.
- Randomised multiplier latency (0-20 cycles), 500 random (x, e, ebits, mode) vectors with WIDTH=16 and odd m, checked against a reference model. Each mult_a/mult_b pair is stable from mult_start until mult_done. start pulses issued while busy have no effect.
- Assert resetn low during OP1_WAIT, then issue a stray mult_done after reset -> the block stays in IDLE with outputs 0. A fresh start then produces the correct res=8.
- WIDTH=512 smoke test: x=2, e=65537, ebits=17, with a 512-bit odd m -> matches the golden model. Multiplication count is 2+17+2 = 21.
